// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the memory bus arbiter.
package mem_bus_pkg;

  localparam int unsigned DefaultAddrW = 9;
  localparam int unsigned DefaultDataW = 16;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StRdata  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner selection: a lone eligible requester wins; on a tie, ptr names the winner.
module rr_pick2 (
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] winner
);

  always_comb begin
    winner = eligible;
    if (eligible == 2'b11) begin
      winner = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester single-port RAM arbiter (CPU = 0, debug loader = 1).
// Define MEM_BUS_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins ties.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  mem_cmd_t          cmd0,
  input  mem_cmd_t          cmd1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output mem_cmd_t          mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  logic              winner_q;
  mem_cmd_t          cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        eligible;
  logic [1:0]        winner;
  logic              take;
  logic              ptr;

  assign eligible[0] = req[0] && (cmd0 == MREAD || cmd0 == MWRITE);
  assign eligible[1] = req[1] && (cmd1 == MREAD || cmd1 == MWRITE);

  rr_pick2 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (winner)
  );

`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
  logic ptr_q;

  // Favour the requester that lost the last granted access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (state_q == StAccess) begin
      ptr_q <= ~winner_q;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          take    = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: state_d = (cmd_q == MREAD) ? StRdata : StIdle;
      StRdata:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      winner_q <= 1'b0;
      cmd_q    <= MNONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        winner_q <= winner[1];
        cmd_q    <= winner[1] ? cmd1 : cmd0;
        addr_q   <= winner[1] ? addr1 : addr0;
        wdata_q  <= winner[1] ? wdata1 : wdata0;
      end
      if (state_q == StRdata) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Address/data only change on a new latch, so they naturally hold between accesses.
  always_comb begin
    gnt       = (state_q == StAccess) ? (2'b01 << winner_q) : 2'b00;
    rvalid    = (state_q == StRdata) ? (2'b01 << winner_q) : 2'b00;
    rdata     = (state_q == StRdata) ? mem_rdata : rdata_q;
    busy      = (state_q != StIdle);
    mem_cmd   = (state_q == StAccess) ? cmd_q : MNONE;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a one-cycle-latency RAM model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req;
  mem_cmd_t      cmd0, cmd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          busy;
  mem_cmd_t      mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .cmd0      (cmd0),
    .cmd1      (cmd1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == MREAD) mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, " gnt"}, 32'(gnt), 32'h0);
    chk({tag, " rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " mem_cmd"}, 32'(mem_cmd), 32'(MNONE));
  endtask

  logic [1:0] exp_gnt [4];

  initial begin
    reset_n = 1'b0;
    req = 2'b00;
    cmd0 = MNONE; cmd1 = MNONE;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;
    tick();
    tick();
    idle_checks("reset");
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    chk("reset mem_wdata", 32'(mem_wdata), 32'h0);
    chk("reset rdata", 32'(rdata), 32'h0);
    reset_n = 1'b1;
    tick();
    idle_checks("post-reset");

    // Single write from requester 0
    req = 2'b01; cmd0 = MWRITE; addr0 = 9'h005; wdata0 = 16'hABCD;
    tick();
    chk("wr gnt", 32'(gnt), 32'h1);
    chk("wr mem_cmd", 32'(mem_cmd), 32'(MWRITE));
    chk("wr mem_addr", 32'(mem_addr), 32'h5);
    chk("wr mem_wdata", 32'(mem_wdata), 32'hABCD);
    chk("wr busy", 32'(busy), 32'h1);
    req = 2'b00; cmd0 = MNONE;
    tick();
    idle_checks("wr done");
    chk("wr hold addr", 32'(mem_addr), 32'h5);
    chk("wr hold wdata", 32'(mem_wdata), 32'hABCD);

    // Put 1234 at address 5, then read it back through requester 1
    req = 2'b01; cmd0 = MWRITE; wdata0 = 16'h1234;
    tick();
    chk("wr2 gnt", 32'(gnt), 32'h1);
    req = 2'b00; cmd0 = MNONE;
    tick();
    req = 2'b10; cmd1 = MREAD; addr1 = 9'h005;
    tick();
    chk("rd gnt", 32'(gnt), 32'h2);
    chk("rd mem_cmd", 32'(mem_cmd), 32'(MREAD));
    chk("rd rvalid early", 32'(rvalid), 32'h0);
    req = 2'b00; cmd1 = MNONE;
    tick();
    chk("rd rvalid", 32'(rvalid), 32'h2);
    chk("rd rdata", 32'(rdata), 32'h1234);
    chk("rd gnt off", 32'(gnt), 32'h0);
    chk("rd mem_cmd off", 32'(mem_cmd), 32'(MNONE));
    chk("rd busy", 32'(busy), 32'h1);
    tick();
    idle_checks("rd done");
    chk("rd hold rdata", 32'(rdata), 32'h1234);

    // Contention: both requesters write continuously
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
`else
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
`endif
    req = 2'b11; cmd0 = MWRITE; cmd1 = MWRITE;
    addr0 = 9'h010; addr1 = 9'h020; wdata0 = 16'h1111; wdata1 = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("cont gnt %0d", k), 32'(gnt), 32'(exp_gnt[k]));
      chk($sformatf("cont addr %0d", k), 32'(mem_addr), exp_gnt[k][1] ? 32'h20 : 32'h10);
      tick();
      chk($sformatf("cont gap %0d", k), 32'(gnt), 32'h0);
    end
    req = 2'b00; cmd0 = MNONE; cmd1 = MNONE;
    tick();

    // Ignored commands
    req = 2'b01; cmd0 = MNONE;
    tick();
    tick();
    idle_checks("ign mnone");
    cmd0 = mem_cmd_t'(2'b11);
    tick();
    tick();
    idle_checks("ign 11");
    req = 2'b00; cmd0 = MNONE;

    // Reset during RDATA of a requester-0 read (round-robin pointer would be 1)
    req = 2'b01; cmd0 = MREAD; addr0 = 9'h005;
    tick();
    chk("rst rd gnt", 32'(gnt), 32'h1);
    req = 2'b00; cmd0 = MNONE;
    tick();
    chk("rst rd rvalid", 32'(rvalid), 32'h1);
    reset_n = 1'b0;
    #1;
    idle_checks("rst mid");
    tick();
    idle_checks("rst held");
    #2;
    reset_n = 1'b1;
    tick();
    idle_checks("rst after");
    tick();
    idle_checks("rst after2");
    req = 2'b11; cmd0 = MWRITE; cmd1 = MWRITE;
    tick();
    chk("rst first gnt", 32'(gnt), 32'h1);
    req = 2'b00; cmd0 = MNONE; cmd1 = MNONE;
    tick();
    idle_checks("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
